// File: rtl/jtag_master_if.sv
// Command bus and JTAG pins between the bit-banged JTAG initiator and its user.
// The master side issues TCK/TMS/TDI and returns captured TDO data.
interface jtag_master_if #(
  parameter int MAX_LEN = 288,
  parameter int LEN_W   = 9
);
  logic               start;
  logic [1:0]         op;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] din;
  logic               busy;
  logic               done;
  logic [MAX_LEN-1:0] dout;
  logic               tck;
  logic               tms;
  logic               tdi;
  logic               tdo;

  modport master (
    input  start, op, len, din, tdo,
    output busy, done, dout, tck, tms, tdi
  );

  modport slave (
    output start, op, len, din, tdo,
    input  busy, done, dout, tck, tms, tdi
  );
endinterface

// File: rtl/jtag_master.sv
// Bit-banged JTAG initiator: runs one Test-Logic-Reset, IR scan or DR scan per
// command against an attached TAP and returns the captured TDO bits.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; tck parked low
// S_TLR   | six steps of tms=1,1,1,1,1,0 -> Run-Test/Idle
// S_HDR   | walk RTI to Shift-DR (1,0,0) or Shift-IR (1,1,0,0)
// S_SHIFT | len steps shifting din out / tdo in; tms=1 on the last step
// S_TRL   | Exit1 -> Update -> Run-Test/Idle (tms=1,0)
// S_FIN   | last busy cycle; done pulses on the following clk
module jtag_master #(
  parameter int MAX_LEN = 288,
  parameter int LEN_W   = 9,
  parameter int CLK_DIV = 4
) (
  input  logic          i_clk,
  input  logic          i_hard_rst,
  jtag_master_if.master io_bus
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TLR,
    S_HDR,
    S_SHIFT,
    S_TRL,
    S_FIN
  } state_t;

  state_t             r_state;
  logic [DIV_W-1:0]   r_div;
  logic [LEN_W-1:0]   r_step;
  logic [LEN_W-1:0]   r_last;
  logic               r_ir;
  logic [MAX_LEN-1:0] r_din;
  logic [MAX_LEN-1:0] r_dout;
  logic               r_tck;
  logic               r_tms;
  logic               r_tdi;
  logic               r_busy;
  logic               r_done;

  logic [LEN_W-1:0]   w_len_sat;
  logic [LEN_W-1:0]   w_step_nx;
  logic               w_active;
  logic               w_half_end;
  logic               w_rise;
  logic               w_fall;
  logic               w_hdr_last;
  logic               w_no_scan;

  assign w_len_sat  = (io_bus.len > LEN_MAX) ? LEN_MAX : io_bus.len;
  assign w_step_nx  = r_step + 1'b1;
  assign w_active   = (r_state == S_TLR) || (r_state == S_HDR) ||
                      (r_state == S_SHIFT) || (r_state == S_TRL);
  assign w_half_end = (r_div == DIV_LAST);
  assign w_rise     = w_active & w_half_end & ~r_tck;
  assign w_fall     = w_active & w_half_end & r_tck;
  assign w_hdr_last = (r_step == (r_ir ? LEN_W'(3) : LEN_W'(2)));
  assign w_no_scan  = (io_bus.op == 2'd3) ||
                      (~io_bus.op[1] && (io_bus.len == '0));

  always_ff @(posedge i_clk) begin
    if (i_hard_rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_step  <= '0;
      r_last  <= '0;
      r_ir    <= 1'b0;
      r_din   <= '0;
      r_dout  <= '0;
      r_tck   <= 1'b0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // One step is a low half then a high half; the step ends where tck falls.
      if (w_active) begin
        r_div <= w_half_end ? '0 : r_div + 1'b1;
        if (w_half_end) r_tck <= ~r_tck;
        if (w_rise && (r_state == S_SHIFT)) r_dout[r_step] <= io_bus.tdo;
      end

      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_busy <= 1'b1;
            r_ir   <= (io_bus.op == 2'd1);
            r_last <= w_len_sat - 1'b1;
            r_din  <= io_bus.din;
            r_dout <= '0;
            r_step <= '0;
            r_div  <= '0;
            r_tck  <= 1'b0;
            r_tdi  <= 1'b0;
            if (w_no_scan) begin
              r_state <= S_FIN;
            end else begin
              r_state <= io_bus.op[1] ? S_TLR : S_HDR;
              r_tms   <= 1'b1;
            end
          end
        end

        S_TLR: begin
          if (w_fall) begin
            if (r_step == LEN_W'(5)) begin
              r_state <= S_FIN;
            end else begin
              r_step <= w_step_nx;
              r_tms  <= (w_step_nx != LEN_W'(5));
            end
          end
        end

        S_HDR: begin
          if (w_fall) begin
            if (w_hdr_last) begin
              r_state <= S_SHIFT;
              r_step  <= '0;
              r_tdi   <= r_din[0];
              r_tms   <= (r_last == '0);
            end else begin
              r_step <= w_step_nx;
              r_tms  <= r_ir & (r_step == '0);
            end
          end
        end

        S_SHIFT: begin
          if (w_fall) begin
            if (r_step == r_last) begin
              r_state <= S_TRL;
              r_step  <= '0;
              r_tms   <= 1'b1;
              r_tdi   <= 1'b0;
            end else begin
              // r_din[0] is always the bit of the current step.
              r_step <= w_step_nx;
              r_din  <= r_din >> 1;
              r_tdi  <= r_din[1];
              r_tms  <= (w_step_nx == r_last);
            end
          end
        end

        S_TRL: begin
          if (w_fall) begin
            if (r_step == LEN_W'(1)) begin
              r_state <= S_FIN;
            end else begin
              r_step <= w_step_nx;
              r_tms  <= 1'b0;
            end
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
          r_step  <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;
  assign io_bus.dout = r_dout;
  assign io_bus.tck  = r_tck;
  assign io_bus.tms  = r_tms;
  assign io_bus.tdi  = r_tdi;

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master driving a small behavioural TAP (IR 5 bits, ID 40 bits,
// config register 69 bits, bypass for all other instructions).
module tb_jtag_master;
  localparam int MAX_LEN = 288;
  localparam int LEN_W   = 9;
  localparam int CLK_DIV = 2;

  localparam logic [39:0] ID_VAL   = 40'hA5_C3_12_34_56;
  localparam logic [68:0] PAT_A    = {5'h15, 64'hDEAD_BEEF_0123_4567};
  localparam logic [44:0] TMS_DR40 = {3'b100, 39'd0, 3'b110};

  logic clk = 1'b0;
  logic hard_rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cmd_busy;
  int   cmd_rises;

  always #5 clk = ~clk;

  jtag_master_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  jtag_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CLK_DIV(CLK_DIV)) dut (
    .i_clk      (clk),
    .i_hard_rst (hard_rst),
    .io_bus     (bus)
  );

  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SDS, T_CDR, T_SDR, T_E1D, T_PDR, T_E2D, T_UDR,
    T_SIS, T_CIR, T_SIR, T_E1I, T_PIR, T_E2I, T_UIR
  } tap_e;

  tap_e               tap_st    = T_TLR;
  logic [4:0]         tap_ir    = 5'h1f;
  logic [4:0]         ir_sr     = '0;
  logic [MAX_LEN-1:0] dr_sr     = '0;
  logic [68:0]        cfg_reg   = '0;
  int                 tck_rises = 0;
  logic [63:0]        tms_hist  = '0;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      T_TLR:   return m ? T_TLR : T_RTI;
      T_RTI:   return m ? T_SDS : T_RTI;
      T_SDS:   return m ? T_SIS : T_CDR;
      T_CDR:   return m ? T_E1D : T_SDR;
      T_SDR:   return m ? T_E1D : T_SDR;
      T_E1D:   return m ? T_UDR : T_PDR;
      T_PDR:   return m ? T_E2D : T_PDR;
      T_E2D:   return m ? T_UDR : T_SDR;
      T_UDR:   return m ? T_SDS : T_RTI;
      T_SIS:   return m ? T_TLR : T_CIR;
      T_CIR:   return m ? T_E1I : T_SIR;
      T_SIR:   return m ? T_E1I : T_SIR;
      T_E1I:   return m ? T_UIR : T_PIR;
      T_PIR:   return m ? T_E2I : T_PIR;
      T_E2I:   return m ? T_UIR : T_SIR;
      T_UIR:   return m ? T_SDS : T_RTI;
      default: return T_TLR;
    endcase
  endfunction

  function automatic int dr_len(input logic [4:0] ir);
    case (ir)
      5'd0:       return 40;
      5'd6, 5'd7: return 69;
      default:    return 1;
    endcase
  endfunction

  always @(posedge bus.tck) begin
    logic [MAX_LEN-1:0] t;
    tck_rises <= tck_rises + 1;
    tms_hist  <= {tms_hist[62:0], bus.tms};
    case (tap_st)
      T_TLR: tap_ir <= 5'h1f;
      T_CIR: ir_sr <= 5'b00001;
      T_SIR: ir_sr <= {bus.tdi, ir_sr[4:1]};
      T_UIR: tap_ir <= ir_sr;
      T_CDR: dr_sr <= (tap_ir == 5'd0) ? MAX_LEN'(ID_VAL) :
                      (tap_ir == 5'd6) ? MAX_LEN'(cfg_reg) : '0;
      T_SDR: begin
        t = dr_sr >> 1;
        t[dr_len(tap_ir) - 1] = bus.tdi;
        dr_sr <= t;
      end
      T_UDR: if (tap_ir == 5'd7) cfg_reg <= dr_sr[68:0];
      default: ;
    endcase
    tap_st <= tap_next(tap_st, bus.tms);
  end

  always @(negedge bus.tck)
    bus.tdo <= (tap_st == T_SDR) ? dr_sr[0] : (tap_st == T_SIR) ? ir_sr[0] : 1'b0;

  task automatic check(input string tag, input logic [MAX_LEN-1:0] got,
                       input logic [MAX_LEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns one clk after done.
  task automatic run_cmd(input string tag, input logic [1:0] op, input int len,
                         input logic [MAX_LEN-1:0] din);
    int rises0;
    int n;
    bus.start = 1'b1;
    bus.op    = op;
    bus.len   = LEN_W'(len);
    bus.din   = din;
    @(negedge clk);
    bus.start = 1'b0;
    rises0    = tck_rises;
    cmd_busy  = 0;
    n         = 0;
    while (!bus.done && n < 3000) begin
      if (bus.busy) cmd_busy++;
      @(negedge clk);
      n++;
    end
    check({tag, " done"}, MAX_LEN'(bus.done), MAX_LEN'(1'b1));
    cmd_rises = tck_rises - rises0;
    @(negedge clk);
  endtask

  initial begin
    int rises0;
    int n;
    int n_done;
    logic [MAX_LEN-1:0] pat;
    logic [MAX_LEN-1:0] exp_sat;

    pat       = {9{32'h1357_9BDF}};
    exp_sat   = pat << 1;
    hard_rst  = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.len   = '0;
    bus.din   = '0;
    repeat (3) @(negedge clk);
    check("rst tck",  MAX_LEN'(bus.tck),  '0);
    check("rst tms",  MAX_LEN'(bus.tms),  MAX_LEN'(1'b1));
    check("rst tdi",  MAX_LEN'(bus.tdi),  '0);
    check("rst busy", MAX_LEN'(bus.busy), '0);
    check("rst done", MAX_LEN'(bus.done), '0);
    check("rst dout", bus.dout, '0);
    hard_rst = 1'b0;
    @(negedge clk);

    // Test-Logic-Reset
    run_cmd("tlr", 2'd2, 0, '0);
    check("tlr rises", MAX_LEN'(cmd_rises), MAX_LEN'(6));
    check("tlr tms",   MAX_LEN'(tms_hist[5:0]), MAX_LEN'(6'b111110));
    check("tlr busy",  MAX_LEN'(cmd_busy), MAX_LEN'(12 * CLK_DIV + 1));
    check("tlr tap",   MAX_LEN'(tap_st), MAX_LEN'(T_RTI));
    check("tlr tck idle", MAX_LEN'(bus.tck), '0);

    // IDRead then 40-bit ID scan
    run_cmd("ir id", 2'd1, 5, '0);
    check("ir capture", bus.dout, MAX_LEN'(5'b00001));
    check("ir busy",    MAX_LEN'(cmd_busy), MAX_LEN'((5 + 6) * 2 * CLK_DIV + 1));
    check("ir loaded",  MAX_LEN'(tap_ir), '0);
    run_cmd("dr id", 2'd0, 40, '0);
    check("id dout",  bus.dout, MAX_LEN'(ID_VAL));
    check("id rises", MAX_LEN'(cmd_rises), MAX_LEN'(45));
    check("id busy",  MAX_LEN'(cmd_busy), MAX_LEN'((40 + 5) * 2 * CLK_DIV + 1));
    check("id tms",   MAX_LEN'(tms_hist[44:0]), MAX_LEN'(TMS_DR40));

    // Write then read back the config register
    run_cmd("ir wrcfg", 2'd1, 5, MAX_LEN'(5'd7));
    run_cmd("dr wrcfg", 2'd0, 69, MAX_LEN'(PAT_A));
    check("cfg reg", MAX_LEN'(cfg_reg), MAX_LEN'(PAT_A));
    run_cmd("ir rdcfg", 2'd1, 5, MAX_LEN'(5'd6));
    run_cmd("dr rdcfg", 2'd0, 69, '0);
    check("cfg dout", bus.dout, MAX_LEN'(PAT_A));

    // Bypass: one bit of delay, first bit out is the captured 0
    run_cmd("ir byp", 2'd1, 5, MAX_LEN'(5'd31));
    run_cmd("dr byp", 2'd0, 8, MAX_LEN'(8'hA5));
    check("byp dout", bus.dout, MAX_LEN'(8'h4A));

    // Reserved op and zero-length scan: no tck activity
    run_cmd("op3", 2'd3, 0, '0);
    check("op3 rises", MAX_LEN'(cmd_rises), '0);
    check("op3 busy",  MAX_LEN'(cmd_busy), MAX_LEN'(1));
    run_cmd("len0", 2'd0, 0, '1);
    check("len0 rises", MAX_LEN'(cmd_rises), '0);
    check("len0 busy",  MAX_LEN'(cmd_busy), MAX_LEN'(1));
    check("len0 dout",  bus.dout, '0);

    // Length above MAX_LEN saturates (bypass still selected)
    run_cmd("sat", 2'd0, 300, pat);
    check("sat rises", MAX_LEN'(cmd_rises), MAX_LEN'(MAX_LEN + 5));
    check("sat dout",  bus.dout, exp_sat);

    // Start while busy is ignored
    rises0    = tck_rises;
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.len   = LEN_W'(3);
    bus.din   = MAX_LEN'(3'b101);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'd2;
    @(negedge clk);
    bus.start = 1'b0;
    n_done    = 0;
    for (int i = 0; i < 80; i++) begin
      if (bus.done) n_done++;
      @(negedge clk);
    end
    check("busy start dones", MAX_LEN'(n_done), MAX_LEN'(1));
    check("busy start rises", MAX_LEN'(tck_rises - rises0), MAX_LEN'(8));
    check("busy start dout",  bus.dout, MAX_LEN'(3'b010));

    // Hard reset in the middle of a 288-bit scan
    run_cmd("ir hcm", 2'd1, 5, MAX_LEN'(5'h0B));
    rises0    = tck_rises;
    bus.start = 1'b1;
    bus.op    = 2'd0;
    bus.len   = LEN_W'(MAX_LEN);
    bus.din   = pat;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while ((tck_rises - rises0) < 104 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("hcm step100", MAX_LEN'(tck_rises - rises0), MAX_LEN'(104));
    check("hcm tck high", MAX_LEN'(bus.tck), MAX_LEN'(1'b1));
    check("hcm dout live", MAX_LEN'(bus.dout != '0), MAX_LEN'(1'b1));
    hard_rst = 1'b1;
    @(negedge clk);
    hard_rst = 1'b0;
    check("abort tck",  MAX_LEN'(bus.tck),  '0);
    check("abort busy", MAX_LEN'(bus.busy), '0);
    check("abort dout", bus.dout, '0);
    check("abort tms",  MAX_LEN'(bus.tms),  MAX_LEN'(1'b1));
    @(negedge clk);
    run_cmd("tlr2", 2'd2, 0, '0);
    check("tlr2 tap", MAX_LEN'(tap_st), MAX_LEN'(T_RTI));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
